// File: rtl/range_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : range_frame_tx
// Purpose  : Buffers up to DEPTH samples and plays them out as one go/finish
//            framed burst followed by a single idle gap cycle.
// Option   : RANGE_FRAME_TX_EXPECT_EN enables the max-min expected_range output
// Revision : 1.0 - initial release
// ============================================================================
module range_frame_tx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_wr_valid,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic                   o_wr_ready,
  input  logic                   i_send,
  output logic                   o_send_err,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_go,
  output logic                   o_finish,
  output logic [WIDTH-1:0]       o_data_out,
  output logic [WIDTH-1:0]       o_expected_range
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_IDX_W + 1;

  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_FIRST  = 2'd1;
  localparam logic [1:0] c_S_STREAM = 2'd2;
  localparam logic [1:0] c_S_GAP    = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [WIDTH-1:0]   r_buf [DEPTH];
  logic [c_CNT_W-1:0] r_count;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_send_err;
  logic               w_wr_fire;
  logic               w_last;

  // Writes are refused while reset is held so a producer never sees a phantom accept.
  assign o_wr_ready = !reset && (r_state == c_S_IDLE) && (r_count < c_FULL) && !i_send;
  assign w_wr_fire  = i_wr_valid && o_wr_ready;
  assign w_last     = ({1'b0, r_idx} == (r_count - c_ONE));
  assign o_count    = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (i_send && (r_count != '0)) begin
          w_next_state = c_S_FIRST;
        end
      end
      c_S_FIRST: begin
        w_next_state = c_S_STREAM;
      end
      c_S_STREAM: begin
        if (w_last) begin
          w_next_state = c_S_GAP;
        end
      end
      c_S_GAP: begin
        w_next_state = c_S_IDLE;
      end
      default: begin
        w_next_state = c_S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_go       = 1'b0;
    o_finish   = 1'b0;
    o_data_out = '0;
    o_busy     = (r_state != c_S_IDLE);
    o_send_err = r_send_err;
    case (r_state)
      c_S_FIRST: begin
        o_go       = 1'b1;
        o_data_out = r_buf[0];
      end
      c_S_STREAM: begin
        o_data_out = r_buf[r_idx];
        o_finish   = w_last;
      end
      default: begin
        o_go       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_send_err <= 1'b0;
    end else begin
      r_send_err <= (r_state == c_S_IDLE) && i_send && (r_count == '0);
      case (r_state)
        c_S_IDLE: begin
          if (w_wr_fire) begin
            r_count <= r_count + c_ONE;
          end
        end
        c_S_FIRST: begin
          // A single-sample frame repeats sample 0 so the frame still spans two beats.
          r_idx <= (r_count == c_ONE) ? '0 : c_IDX_ONE;
        end
        c_S_STREAM: begin
          if (!w_last) begin
            r_idx <= r_idx + c_IDX_ONE;
          end
        end
        default: begin
          r_count <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_fire) begin
      r_buf[r_count[c_IDX_W-1:0]] <= i_wr_data;
    end
  end

`ifdef RANGE_FRAME_TX_EXPECT_EN
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;

  always_ff @(posedge clock) begin
    if (reset || (r_state == c_S_GAP)) begin
      r_max <= '0;
      r_min <= '0;
    end else if (w_wr_fire) begin
      if (r_count == '0) begin
        r_max <= i_wr_data;
        r_min <= i_wr_data;
      end else begin
        if (i_wr_data > r_max) begin
          r_max <= i_wr_data;
        end
        if (i_wr_data < r_min) begin
          r_min <= i_wr_data;
        end
      end
    end
  end

  assign o_expected_range = r_max - r_min;
`else
  assign o_expected_range = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_range_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_frame_tx
// Purpose  : Directed and randomized frame checks for range_frame_tx against a
//            queue-based model of the buffer and frame rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_frame_tx;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   wr_valid;
  logic [WIDTH-1:0]       wr_data;
  logic                   wr_ready;
  logic                   send;
  logic                   send_err;
  logic                   busy;
  logic [$clog2(DEPTH):0] count;
  logic                   go;
  logic                   finish;
  logic [WIDTH-1:0]       data_out;
  logic [WIDTH-1:0]       expected_range;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];

  range_frame_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .i_wr_valid       (wr_valid),
    .i_wr_data        (wr_data),
    .o_wr_ready       (wr_ready),
    .i_send           (send),
    .o_send_err       (send_err),
    .o_busy           (busy),
    .o_count          (count),
    .o_go             (go),
    .o_finish         (finish),
    .o_data_out       (data_out),
    .o_expected_range (expected_range)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_range();
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    if (q.size() == 0) return '0;
    mx = q[0];
    mn = q[0];
    foreach (q[i]) begin
      if (q[i] > mx) mx = q[i];
      if (q[i] < mn) mn = q[i];
    end
`ifdef RANGE_FRAME_TX_EXPECT_EN
    return mx - mn;
`else
    return '0;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    logic exp_rdy;
    exp_rdy  = (q.size() < DEPTH);
    wr_valid = 1'b1;
    wr_data  = d;
    #1;
    chk("wr_ready", 32'(wr_ready), 32'(exp_rdy));
    tick();
    wr_valid = 1'b0;
    if (exp_rdy) q.push_back(d);
    chk("count", 32'(count), 32'(q.size()));
    chk("exp_range", 32'(expected_range), 32'(model_range()));
  endtask

  // Sends the modelled buffer and walks the whole frame, gap and return to idle.
  task automatic send_frame(input logic with_write, input logic resend);
    int n;
    logic [WIDTH-1:0] rng;
    n   = q.size();
    rng = model_range();
    send = 1'b1;
    if (with_write) begin
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
    end
    #1;
    chk("wr_ready_on_send", 32'(wr_ready), 32'd0);
    tick();
    send     = 1'b0;
    wr_valid = 1'b0;
    if (resend) send = 1'b1;
    chk("first_busy", 32'(busy), 32'd1);
    chk("first_go", 32'(go), 32'd1);
    chk("first_finish", 32'(finish), 32'd0);
    chk("first_data", 32'(data_out), 32'(q[0]));
    chk("count_held", 32'(count), 32'(n));
    chk("range_held", 32'(expected_range), 32'(rng));
    tick();
    send = 1'b0;
    for (int i = (n == 1) ? 0 : 1; i < n; i++) begin
      chk("beat_go", 32'(go), 32'd0);
      chk("beat_data", 32'(data_out), 32'(q[i]));
      chk("beat_finish", 32'(finish), 32'(i == n - 1));
      chk("beat_busy", 32'(busy), 32'd1);
      if (i < n - 1) tick();
    end
    tick();
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_go_finish", 32'({go, finish}), 32'd0);
    chk("gap_data", 32'(data_out), 32'd0);
    chk("gap_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    q.delete();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_wr_ready", 32'(wr_ready), 32'd1);
    chk("idle_range", 32'(expected_range), 32'd0);
    chk("idle_send_err", 32'(send_err), 32'd0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    send     = 1'b0;
    repeat (3) tick();
    chk("rst_outputs", 32'({go, finish, busy, send_err}), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_range", 32'(expected_range), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    // Basic four-sample frame.
    wr(8'd5); wr(8'd9); wr(8'd2); wr(8'd7);
    send_frame(1'b0, 1'b0);

    // Single sample is repeated with finish on the second beat.
    wr(8'h42);
    send_frame(1'b0, 1'b0);

    // Empty-buffer send.
    send = 1'b1;
    tick();
    send = 1'b0;
    chk("err_pulse", 32'(send_err), 32'd1);
    chk("err_quiet", 32'({busy, go, finish}), 32'd0);
    tick();
    chk("err_once", 32'(send_err), 32'd0);
    chk("err_still_idle", 32'(busy), 32'd0);

    // Fill completely, then a dropped 17th write.
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    wr(8'hAA);
    chk("full_count", 32'(count), 32'(DEPTH));
    send_frame(1'b0, 1'b0);

    // Write refused in the send cycle, second send ignored while busy.
    wr(8'h10); wr(8'h30); wr(8'h20);
    send_frame(1'b1, 1'b1);

    // Reset in STREAM with idx 2.
    for (int i = 0; i < 5; i++) wr(8'($urandom));
    send = 1'b1;
    tick();
    send = 1'b0;
    tick();
    tick();
    chk("pre_abort_data", 32'(data_out), 32'(q[2]));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    chk("abort_go_finish", 32'({go, finish}), 32'd0);
    chk("abort_data", 32'(data_out), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    #1;
    chk("abort_wr_ready", 32'(wr_ready), 32'd1);
    tick();

    // Randomized frames of random length.
    repeat (8) begin
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) wr(8'($urandom));
      send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
